// File: rtl/ntsc_timing_pkg.sv
// Shared constants, counter widths and line classification for the NTSC 240p timing generator.
package ntsc_timing_pkg;

    localparam int H_W = 11;
    localparam int V_W = 9;

    localparam int DEF_H_TOTAL        = 1716;
    localparam int DEF_H_SYNC_LEN     = 127;
    localparam int DEF_EQ_LEN         = 63;
    localparam int DEF_BURST_START    = 143;
    localparam int DEF_BURST_LEN      = 68;
    localparam int DEF_ACTIVE_START   = 316;
    localparam int DEF_H_PIXELS       = 320;
    localparam int DEF_PIX_DIV        = 4;
    localparam int DEF_V_TOTAL        = 262;
    localparam int DEF_V_ACTIVE_START = 22;
    localparam int DEF_V_PIXELS       = 240;

    typedef enum logic [1:0] {
        LINE_EQ,
        LINE_BROAD,
        LINE_NORMAL
    } line_type_t;

    // Lines 0-2 and 6-8 carry equalising pulses, 3-5 the broad vertical sync.
    function automatic line_type_t line_type(input logic [V_W-1:0] v);
        line_type_t lt;
        if (v <= 9'd2 || (v >= 9'd6 && v <= 9'd8)) begin
            lt = LINE_EQ;
        end else if (v >= 9'd3 && v <= 9'd5) begin
            lt = LINE_BROAD;
        end else begin
            lt = LINE_NORMAL;
        end
        return lt;
    endfunction

endpackage

// File: rtl/ntsc_hv_counter.sv
// Horizontal/vertical raster counters; en low parks both at the frame origin.
module ntsc_hv_counter
    import ntsc_timing_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic           clk_27m,
    input  logic           rst_n,
    input  logic           en,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           h_wrap,
    output logic           v_wrap
);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = h_wrap && (v_cnt == V_LAST);

    // Advance h every enabled clock, bump v on the line wrap.
    always_ff @(posedge clk_27m or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 9'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

endmodule

// File: rtl/ntsc_timing_gen.sv
// NTSC 240p raster timing: composite sync, blanking, burst gate and pixel strobe.
// Every output is a registered decode of the counter state one clock earlier.
module ntsc_timing_gen
    import ntsc_timing_pkg::*;
#(
    parameter int H_TOTAL        = DEF_H_TOTAL,
    parameter int H_SYNC_LEN     = DEF_H_SYNC_LEN,
    parameter int EQ_LEN         = DEF_EQ_LEN,
    parameter int BURST_START    = DEF_BURST_START,
    parameter int BURST_LEN      = DEF_BURST_LEN,
    parameter int ACTIVE_START   = DEF_ACTIVE_START,
    parameter int H_PIXELS       = DEF_H_PIXELS,
    parameter int PIX_DIV        = DEF_PIX_DIV,
    parameter int V_TOTAL        = DEF_V_TOTAL,
    parameter int V_ACTIVE_START = DEF_V_ACTIVE_START,
    parameter int V_PIXELS       = DEF_V_PIXELS
) (
    input  logic       clk_27m,
    input  logic       rst_n,
    input  logic       en,
    output logic       sync_n,
    output logic       blank,
    output logic       burst_gate,
    output logic       pix_stb,
    output logic [8:0] pix_x,
    output logic [7:0] pix_y,
    output logic       line_start,
    output logic       frame_start
);

    if (ACTIVE_START + H_PIXELS * PIX_DIV > H_TOTAL) begin : g_chk_h_active
        $error("active window runs past the end of the line");
    end
    if (BURST_START + BURST_LEN > ACTIVE_START) begin : g_chk_burst
        $error("burst window overlaps the active window");
    end
    if (H_TOTAL % 2 != 0) begin : g_chk_h_even
        $error("H_TOTAL must be even");
    end
    if (V_ACTIVE_START + V_PIXELS > V_TOTAL) begin : g_chk_v_active
        $error("active lines run past the end of the frame");
    end
    if (V_ACTIVE_START < 9) begin : g_chk_v_start
        $error("active picture overlaps the vertical sync interval");
    end

    localparam int PH_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [H_W-1:0] H_HALF     = H_W'(H_TOTAL / 2);
    localparam logic [H_W-1:0] H_EQ_END1  = H_W'(EQ_LEN);
    localparam logic [H_W-1:0] H_EQ_END2  = H_W'(H_TOTAL / 2 + EQ_LEN);
    localparam logic [H_W-1:0] H_BR_END1  = H_W'(H_TOTAL / 2 - H_SYNC_LEN);
    localparam logic [H_W-1:0] H_BR_END2  = H_W'(H_TOTAL - H_SYNC_LEN);
    localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_SYNC_LEN);
    localparam logic [H_W-1:0] H_BURST_S  = H_W'(BURST_START);
    localparam logic [H_W-1:0] H_BURST_E  = H_W'(BURST_START + BURST_LEN);
    localparam logic [H_W-1:0] H_ACT_S    = H_W'(ACTIVE_START);
    localparam logic [H_W-1:0] H_ACT_E    = H_W'(ACTIVE_START + H_PIXELS * PIX_DIV);
    localparam logic [V_W-1:0] V_ACT_S    = V_W'(V_ACTIVE_START);
    localparam logic [V_W-1:0] V_ACT_E    = V_W'(V_ACTIVE_START + V_PIXELS);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(PIX_DIV - 1);

    logic [H_W-1:0]  h_cnt;
    logic [V_W-1:0]  v_cnt;
    logic            h_wrap;
    logic            v_wrap;
    line_type_t      lt;
    logic            sync_low;
    logic            burst_d;
    logic            act_line;
    logic            in_win;
    logic            stb_d;
    logic [PH_W-1:0] phase_q;
    logic [8:0]      col_q;
    logic            sol_q;
    logic            sof_q;

    ntsc_hv_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_hv_counter (
        .clk_27m (clk_27m),
        .rst_n   (rst_n),
        .en      (en),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .h_wrap  (h_wrap),
        .v_wrap  (v_wrap)
    );

    // Decode sync shape, burst and active window from the current raster position.
    always_comb begin
        lt       = line_type(v_cnt);
        sync_low = 1'b0;
        case (lt)
            LINE_EQ:    sync_low = (h_cnt < H_EQ_END1) ||
                                   (h_cnt >= H_HALF && h_cnt < H_EQ_END2);
            LINE_BROAD: sync_low = (h_cnt < H_BR_END1) ||
                                   (h_cnt >= H_HALF && h_cnt < H_BR_END2);
            default:    sync_low = (h_cnt < H_SYNC_END);
        endcase
        burst_d  = (lt == LINE_NORMAL) && (h_cnt >= H_BURST_S) && (h_cnt < H_BURST_E);
        act_line = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
        in_win   = act_line && (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
        stb_d    = in_win && (phase_q == '0);
    end

    // Pixel divider and column count track h inside the window; the line/frame
    // origin flags are the registered wrap flags, so they are true while h=0 (and v=0).
    always_ff @(posedge clk_27m or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            col_q   <= '0;
            sol_q   <= 1'b1;
            sof_q   <= 1'b1;
        end else if (!en) begin
            phase_q <= '0;
            col_q   <= '0;
            sol_q   <= 1'b1;
            sof_q   <= 1'b1;
        end else begin
            sol_q <= h_wrap;
            sof_q <= v_wrap;
            if (in_win) begin
                if (phase_q == PH_LAST) begin
                    phase_q <= '0;
                    col_q   <= col_q + 9'd1;
                end else begin
                    phase_q <= phase_q + PH_W'(1);
                end
            end else begin
                phase_q <= '0;
                col_q   <= '0;
            end
        end
    end

    // Register all outputs; pix_x/pix_y only load on a strobe and hold otherwise.
    always_ff @(posedge clk_27m or negedge rst_n) begin
        if (!rst_n) begin
            sync_n      <= 1'b1;
            blank       <= 1'b1;
            burst_gate  <= 1'b0;
            pix_stb     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            sync_n      <= 1'b1;
            blank       <= 1'b1;
            burst_gate  <= 1'b0;
            pix_stb     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            sync_n      <= ~sync_low;
            blank       <= ~in_win;
            burst_gate  <= burst_d;
            pix_stb     <= stb_d;
            line_start  <= sol_q;
            frame_start <= sol_q && sof_q;
            if (stb_d) begin
                pix_x <= col_q;
                pix_y <= 8'(v_cnt - V_ACT_S);
            end
        end
    end

endmodule

// File: tb/tb_ntsc_timing_gen.sv
// Bench for ntsc_timing_gen: one instance with default timing over the first 23+ lines,
// one with a shrunken raster over several frames with random en drops and async resets.
`timescale 1ns/1ps
module tb_ntsc_timing_gen;

    localparam int DH = 1716, DHS = 127, DEQ = 63, DBS = 143, DBL = 68;
    localparam int DAS = 316, DHP = 320, DPD = 4, DV = 262, DVAS = 22, DVP = 240;

    localparam int SH = 100, SHS = 8, SEQ = 4, SBS = 10, SBL = 6;
    localparam int SAS = 20, SHP = 16, SPD = 4, SV = 40, SVAS = 9, SVP = 20;

    localparam logic [22:0] IDLE = 23'h600000;

    localparam int DEF_DROP  = 23 * DH + 500;
    localparam int DEF_RST   = 23 * DH + 1100;
    localparam int DEF_RUN   = 23 * DH + 1400;
    localparam int SMALL_RUN = 18000;

    logic clk = 1'b0;
    always #18 clk = ~clk;

    logic rst_d = 1'b0, en_d = 1'b0, rst_s = 1'b0, en_s = 1'b0;
    logic sync_n_d, blank_d, burst_d, stb_d, ls_d, fs_d;
    logic sync_n_s, blank_s, burst_s, stb_s, ls_s, fs_s;
    logic [8:0] px_d, px_s;
    logic [7:0] py_d, py_s;
    logic [22:0] obs_d, obs_s;

    assign obs_d = {sync_n_d, blank_d, burst_d, stb_d, ls_d, fs_d, px_d, py_d};
    assign obs_s = {sync_n_s, blank_s, burst_s, stb_s, ls_s, fs_s, px_s, py_s};

    int n_cmp = 0;
    int n_err = 0;

    ntsc_timing_gen u_dut_def (
        .clk_27m     (clk),
        .rst_n       (rst_d),
        .en          (en_d),
        .sync_n      (sync_n_d),
        .blank       (blank_d),
        .burst_gate  (burst_d),
        .pix_stb     (stb_d),
        .pix_x       (px_d),
        .pix_y       (py_d),
        .line_start  (ls_d),
        .frame_start (fs_d)
    );

    ntsc_timing_gen #(
        .H_TOTAL(SH), .H_SYNC_LEN(SHS), .EQ_LEN(SEQ), .BURST_START(SBS), .BURST_LEN(SBL),
        .ACTIVE_START(SAS), .H_PIXELS(SHP), .PIX_DIV(SPD), .V_TOTAL(SV),
        .V_ACTIVE_START(SVAS), .V_PIXELS(SVP)
    ) u_dut_small (
        .clk_27m     (clk),
        .rst_n       (rst_s),
        .en          (en_s),
        .sync_n      (sync_n_s),
        .blank       (blank_s),
        .burst_gate  (burst_s),
        .pix_stb     (stb_s),
        .pix_x       (px_s),
        .pix_y       (py_s),
        .line_start  (ls_s),
        .frame_start (fs_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs for raster position p (enabled clocks since the last restart).
    function automatic logic [22:0] ref_decode(input int p, input int ht, input int hs,
                                               input int eql, input int bs, input int bl,
                                               input int ast, input int hp, input int pd,
                                               input int vt, input int vas, input int vp,
                                               input logic [8:0] px_old, input logic [7:0] py_old);
        int h;
        int v;
        bit is_eq;
        bit is_broad;
        bit sl;
        bit win;
        bit stb;
        bit bg;
        logic [8:0] px;
        logic [7:0] py;
        h        = p % ht;
        v        = (p / ht) % vt;
        is_eq    = (v <= 2) || (v >= 6 && v <= 8);
        is_broad = (v >= 3 && v <= 5);
        if (is_eq)
            sl = (h < eql) || (h >= ht / 2 && h < ht / 2 + eql);
        else if (is_broad)
            sl = (h < ht / 2 - hs) || (h >= ht / 2 && h < ht - hs);
        else
            sl = (h < hs);
        bg  = !is_eq && !is_broad && h >= bs && h < bs + bl;
        win = (v >= vas) && (v < vas + vp) && (h >= ast) && (h < ast + hp * pd);
        stb = win && ((h - ast) % pd == 0);
        px  = stb ? 9'((h - ast) / pd) : px_old;
        py  = stb ? 8'(v - vas) : py_old;
        return {!sl, !win, bg, stb, h == 0, (h == 0) && (v == 0), px, py};
    endfunction

    task automatic run_def();
        int pos;
        logic [8:0] epx;
        logic [7:0] epy;
        logic [22:0] exp;
        pos = 0; epx = '0; epy = '0;
        rst_d = 1'b0;
        en_d  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("def_reset", obs_d, IDLE);
        rst_d = 1'b1;
        for (int c = 0; c < DEF_RUN; c++) begin
            if (c == DEF_DROP) en_d = 1'b0;
            if (c == DEF_DROP + 3) en_d = 1'b1;
            if (en_d) begin
                exp = ref_decode(pos, DH, DHS, DEQ, DBS, DBL, DAS, DHP, DPD, DV, DVAS, DVP, epx, epy);
                epx = exp[16:8];
                epy = exp[7:0];
                pos = (pos + 1) % (DH * DV);
            end else begin
                exp = IDLE;
                pos = 0; epx = '0; epy = '0;
            end
            @(negedge clk);
            check_eq("def_run", obs_d, exp);
            if (c == DEF_RST) begin
                #4 rst_d = 1'b0;
                #1 check_eq("def_async_rst", obs_d, IDLE);
                pos = 0; epx = '0; epy = '0;
                #3 rst_d = 1'b1;
            end
        end
    endtask

    task automatic run_small();
        int pos;
        int off_cnt;
        int last_fs;
        bit dropped;
        logic [8:0] epx;
        logic [7:0] epy;
        logic [22:0] exp;
        pos = 0; off_cnt = 0; last_fs = -1; dropped = 1'b0; epx = '0; epy = '0;
        rst_s = 1'b0;
        en_s  = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("small_reset", obs_s, IDLE);
        rst_s = 1'b1;
        en_s  = 1'b1;
        for (int c = 0; c < SMALL_RUN; c++) begin
            if (off_cnt > 0) begin
                off_cnt--;
                if (off_cnt == 0) en_s = 1'b1;
            end else if (c >= 10000 && !dropped && pos == 30 * SH + 50) begin
                en_s    = 1'b0;
                off_cnt = 2;
                dropped = 1'b1;
            end else if (c >= 12500 && en_s && $urandom_range(0, 299) == 0) begin
                en_s    = 1'b0;
                off_cnt = int'($urandom_range(1, 6));
            end
            if (en_s) begin
                exp = ref_decode(pos, SH, SHS, SEQ, SBS, SBL, SAS, SHP, SPD, SV, SVAS, SVP, epx, epy);
                epx = exp[16:8];
                epy = exp[7:0];
                pos = (pos + 1) % (SH * SV);
            end else begin
                exp = IDLE;
                pos = 0; epx = '0; epy = '0;
            end
            @(negedge clk);
            check_eq("small_run", obs_s, exp);
            if (c < 10000 && obs_s[17]) begin
                if (last_fs >= 0) check_eq("frame_period", c - last_fs, SH * SV);
                last_fs = c;
            end
            if (c >= 12500 && $urandom_range(0, 699) == 0) begin
                #4 rst_s = 1'b0;
                #1 check_eq("small_async_rst", obs_s, IDLE);
                pos = 0; epx = '0; epy = '0;
                #3 rst_s = 1'b1;
            end
        end
    endtask

    initial begin
        fork
            run_def();
            run_small();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ntsc_timing_gen.md
Name: ntsc_timing_gen

Overview:
- Free-running NTSC 240p raster timing generator. It sits directly upstream of the luma/chroma encoder that drives ntsc_luma, ntsc_chroma and ntsc_sync.
- Produces composite sync, blanking, colour-burst gate and a pixel request strobe with x/y coordinates, all at 27 MHz.
- Consumers are the framebuffer reader, which uses pix_stb/pix_x/pix_y, and the encoder, which uses sync_n, blank and burst_gate.

Parameters:
- H_TOTAL, 1716: clocks per line (63.56 us).
- H_SYNC_LEN, 127: horizontal sync low width (4.7 us).
- EQ_LEN, 63: equalising pulse low width.
- BURST_START, 143: first burst_gate clock in the line.
- BURST_LEN, 68: burst_gate width.
- ACTIVE_START, 316: h count of the first pixel strobe.
- H_PIXELS, 320: pixels per line.
- PIX_DIV, 4: clocks per pixel.
- V_TOTAL, 262: lines per frame.
- V_ACTIVE_START, 22: first active line.
- V_PIXELS, 240: active lines.

Ports:
- clk_27m, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: run enable (tie to PLL lock). Low forces the idle state.
- sync_n, output, 1: composite sync, active low.
- blank, output, 1: high outside the active picture.
- burst_gate, output, 1: high during the colour-burst window.
- pix_stb, output, 1: one-cycle pixel request.
- pix_x, output, 9: pixel column, valid with pix_stb.
- pix_y, output, 8: pixel row, valid with pix_stb.
- line_start, output, 1: one-cycle pulse at h=0.
- frame_start, output, 1: one-cycle pulse at h=0, v=0.

Behaviour:
- Reset (async, rst_n=0) and en=0 both force the same state:
  - Counters: h_cnt=0, v_cnt=0.
  - Outputs: sync_n=1, blank=1, burst_gate=0, pix_stb=0, pix_x=0, pix_y=0, line_start=0, frame_start=0.
  - en=0 is synchronous: the state is reached on the next edge.
- Counters (only while en=1):
  - h_cnt is 11 bits, counts 0..H_TOTAL-1 and wraps to 0.
  - At the wrap, v_cnt (9 bits) increments over 0..V_TOTAL-1 and wraps to 0.
- Output latency: all outputs are registered and decoded from the current counter values. Each output therefore appears 1 cycle after the counter state that caused it.
  - The first edge with en=1 registers the h=0, v=0 decode.
  - h_cnt advances on every en=1 edge.
- Line types:
  - Lines 0-2 and 6-8 (equalising): sync_n low for h in [0, EQ_LEN) and [H_TOTAL/2, H_TOTAL/2+EQ_LEN).
  - Lines 3-5 (broad/serrated): sync_n low for h in [0, H_TOTAL/2-H_SYNC_LEN) and [H_TOTAL/2, H_TOTAL-H_SYNC_LEN).
  - All other lines (normal): sync_n low for h in [0, H_SYNC_LEN).
- burst_gate:
  - High for h in [BURST_START, BURST_START+BURST_LEN) on normal lines only.
  - Suppressed on lines 0-8.
- Active window: active line means V_ACTIVE_START <= v < V_ACTIVE_START+V_PIXELS.
  - blank=0 only on active lines, for h in [ACTIVE_START, ACTIVE_START+H_PIXELS*PIX_DIV).
  - blank=1 everywhere else.
- Pixel strobe:
  - pix_stb=1 when the line is active, h >= ACTIVE_START and (h-ACTIVE_START) mod PIX_DIV == 0, within the active window.
  - pix_x=(h-ACTIVE_START)/PIX_DIV. Use a divider counter, not a true divide.
  - pix_y=v-V_ACTIVE_START.
  - pix_x and pix_y hold their last values when pix_stb=0.
- Pulses: line_start at h=0 decode; frame_start at h=0, v=0 decode. Both are high for exactly one cycle.
- Elaboration checks (error if violated):
  - ACTIVE_START+H_PIXELS*PIX_DIV <= H_TOTAL.
  - BURST_START+BURST_LEN <= ACTIVE_START.
  - H_TOTAL is even.
  - V_ACTIVE_START+V_PIXELS <= V_TOTAL.
  - V_ACTIVE_START >= 9.
- Simultaneous events: h wrap and v wrap on the same cycle yield frame_start and line_start together.
- Mid-frame en drop or reset: no partial pulses survive. The restart is always from line 0, h 0.

Decomposition:
- Package ntsc_timing_pkg holds:
  - Default timing constants.
  - Line-type encoding: LINE_EQ, LINE_BROAD, LINE_NORMAL.
  - Counter widths: H_W=11, V_W=9.
- One sub-module, ntsc_hv_counter: h/v counters with en/clear and wrap flags.
- Sync, burst, blank and pixel decode stay in ntsc_timing_gen.

Test Plan:
- Reset release with en=1:
  - frame_start and line_start high on edge 1 only.
  - sync_n low for exactly 63 cycles, then low again 858 clocks after the first fall (line 0 equalising).
- Line 3: two sync_n low pulses of 731 clocks each, starting 858 apart. burst_gate stays 0 for all of lines 0-8.
- Line 9 (normal): sync_n low for 127 cycles; burst_gate high for 68 cycles starting at h=143; blank=1 for the whole line.
- Line 22:
  - Strobes: 320 pix_stb pulses spaced 4 clocks apart, first at h=316 with pix_x=0, pix_y=0, last with pix_x=319.
  - blank=0 for 1280 cycles.
  - Line 261 shows pix_y=239; line 0 of the next frame has no strobes.
- Frame period: frame_start pulses exactly 449592 cycles apart (1716*262); line_start pulses 1716 apart.
- Mid-operation interruption:
  - en deasserted at line 100, h=500: the next edge shows all outputs idle. Re-assert restarts with frame_start.
  - Async rst_n pulse mid-line: outputs idle immediately, without waiting for a clock edge.
